// File: rtl/led_bit_encoder.sv
// Serial encoder for WS281x-style LED data: turns shift-register bits into timed high/low pulses, then a latch gap.
// Defining LED_ENC_OUT_INV_EN inverts led_dout (idle level 1) for an inverting level shifter.
module led_bit_encoder #(
    parameter int T0H_CYCLES   = 20,
    parameter int T1H_CYCLES   = 40,
    parameter int BIT_CYCLES   = 63,
    parameter int LATCH_CYCLES = 2500
) (
    input  logic clk,
    input  logic reset,
    input  logic word_valid,
    input  logic bit_val,
    input  logic last_bit,
    output logic load,
    output logic next_bit,
    output logic led_dout,
    output logic busy,
    output logic frame_done
);

    localparam int CNT_MAX = (BIT_CYCLES > LATCH_CYCLES) ? BIT_CYCLES : LATCH_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] T0H_LAST   = CNT_W'(T0H_CYCLES - 1);
    localparam logic [CNT_W-1:0] T1H_LAST   = CNT_W'(T1H_CYCLES - 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);

`ifdef LED_ENC_OUT_INV_EN
    localparam logic IDLE_LEVEL = 1'b1;
`else
    localparam logic IDLE_LEVEL = 1'b0;
`endif

    if (!(T0H_CYCLES >= 1 && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES)) begin : g_bad_bit_timing
        $error("led_bit_encoder: need 1 <= T0H_CYCLES < T1H_CYCLES < BIT_CYCLES");
    end
    if (LATCH_CYCLES < 1) begin : g_bad_latch
        $error("led_bit_encoder: LATCH_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_LATCH
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_dout;
    logic [CNT_W-1:0] w_high_last;

    // Counter runs from HIGH entry through the end of LOW, so one bit period is exactly BIT_CYCLES.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dout  <= IDLE_LEVEL;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_dout  <= (w_state_next == S_HIGH) ? ~IDLE_LEVEL : IDLE_LEVEL;
        end
    end

    assign w_high_last = bit_val ? T1H_LAST : T0H_LAST;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        load         = 1'b0;
        next_bit     = 1'b0;
        frame_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (word_valid && reset) begin
                    load         = 1'b1;
                    w_state_next = S_HIGH;
                end
            end
            S_HIGH: begin
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt >= w_high_last) begin
                    w_state_next = S_LOW;
                end
            end
            S_LOW: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_next = '0;
                    if (!last_bit) begin
                        next_bit     = 1'b1;
                        w_state_next = S_HIGH;
                    end else if (word_valid) begin
                        load         = 1'b1;
                        w_state_next = S_HIGH;
                    end else begin
                        w_state_next = S_LATCH;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_LATCH: begin
                if (r_cnt == LATCH_LAST) begin
                    frame_done   = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign busy     = (r_state != S_IDLE);
    assign led_dout = r_dout;

endmodule

// File: tb/tb_led_bit_encoder.sv
// Directed bench for led_bit_encoder with T0H=2, T1H=4, BIT=6, LATCH=10 and a 4-bit upstream shift register.
// Follows LED_ENC_OUT_INV_EN when defined, expecting an inverted led_dout.
module tb_led_bit_encoder;

`ifdef LED_ENC_OUT_INV_EN
    localparam logic IDLE_LVL = 1'b1;
`else
    localparam logic IDLE_LVL = 1'b0;
`endif
    localparam int MAXC = 128;

    logic clk = 1'b0;
    logic reset;
    logic word_valid;
    logic bitVal;
    logic lastBit;
    logic load;
    logic next_bit;
    logic led_dout;
    logic busy;
    logic frame_done;

    logic [3:0] pendingWord;
    logic [3:0] srWord;
    logic [1:0] srIdx;
    logic [3:0] wordList [0:3];
    int         wordPtr;

    bit         schedValid [0:MAXC-1];
    bit         expLoad    [0:MAXC-1];
    bit         expNext    [0:MAXC-1];
    bit         expBusy    [0:MAXC-1];
    bit         expFrame   [0:MAXC-1];
    bit         expLed     [0:MAXC-1];
    logic [4:0] obsVec     [0:MAXC-1];

    int nCompared = 0;
    int nMismatch = 0;

    led_bit_encoder #(
        .T0H_CYCLES  (2),
        .T1H_CYCLES  (4),
        .BIT_CYCLES  (6),
        .LATCH_CYCLES(10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .word_valid(word_valid),
        .bit_val   (bitVal),
        .last_bit  (lastBit),
        .load      (load),
        .next_bit  (next_bit),
        .led_dout  (led_dout),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Upstream shift register: MSB first, captures pendingWord on load, steps on next_bit.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            srWord <= 4'd0;
            srIdx  <= 2'd0;
        end else if (load) begin
            srWord <= pendingWord;
            srIdx  <= 2'd0;
        end else if (next_bit) begin
            srIdx <= srIdx + 2'd1;
        end
    end

    assign bitVal  = srWord[2'd3 - srIdx];
    assign lastBit = (srIdx == 2'd3);

    task automatic clearExp();
        for (int c = 0; c < MAXC; c++) begin
            schedValid[c] = 1'b0;
            expLoad[c]    = 1'b0;
            expNext[c]    = 1'b0;
            expBusy[c]    = 1'b0;
            expFrame[c]   = 1'b0;
            expLed[c]     = 1'b0;
        end
    endtask

    // Word loaded at cycle s: each bit starts s+1+6i, high 4 (one) or 2 (zero) clocks.
    task automatic markWord(input int s, input logic [3:0] w);
        expLoad[s] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int b;
            int hi;
            b  = s + 1 + 6 * i;
            hi = w[3-i] ? 4 : 2;
            for (int k = 0; k < 6; k++) expBusy[b+k] = 1'b1;
            for (int k = 0; k < hi; k++) expLed[b+k] = 1'b1;
            if (i < 3) expNext[b+5] = 1'b1;
        end
    endtask

    task automatic markLatch(input int s);
        for (int k = 0; k < 10; k++) expBusy[s+k] = 1'b1;
        expFrame[s+9] = 1'b1;
    endtask

    // Runs n cycles from posedge+1, driving word_valid from schedValid and recording outputs at negedge.
    task automatic runCapture(input int n);
        wordPtr     = 0;
        pendingWord = wordList[0];
        for (int c = 0; c < n; c++) begin
            word_valid = schedValid[c];
            @(negedge clk);
            obsVec[c] = {load, next_bit, busy, frame_done, led_dout};
            @(posedge clk);
            #1;
            if (obsVec[c][4] && wordPtr < 3) begin
                wordPtr     = wordPtr + 1;
                pendingWord = wordList[wordPtr];
            end
        end
        word_valid = 1'b0;
    endtask

    task automatic test_reset();
        word_valid = 1'b1;
        #2;
        nCompared++;
        if ({load, next_bit, busy, frame_done, led_dout} !== {4'b0000, IDLE_LVL}) begin
            nMismatch++;
            $display("[TB] FAIL reset_outputs: got %b want %b", {load, next_bit, busy, frame_done, led_dout}, {4'b0000, IDLE_LVL});
        end
        word_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            nCompared++;
            if ({load, busy, led_dout} !== {2'b00, IDLE_LVL}) begin
                nMismatch++;
                $display("[TB] FAIL post_reset_idle c%0d: got %b want %b", c, {load, busy, led_dout}, {2'b00, IDLE_LVL});
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_single_word();
        clearExp();
        wordList[0] = 4'b1010;
        wordList[1] = 4'b0000;
        schedValid[0] = 1'b1;
        markWord(0, 4'b1010);
        markLatch(25);
        runCapture(40);
        for (int c = 0; c < 40; c++) begin
            logic [4:0] e;
            e = {expLoad[c], expNext[c], expBusy[c], expFrame[c], expLed[c] ^ IDLE_LVL};
            nCompared++;
            if (obsVec[c] !== e) begin
                nMismatch++;
                $display("[TB] FAIL single_word c%0d {load,next,busy,done,dout}: got %b want %b", c, obsVec[c], e);
            end
        end
    endtask

    task automatic test_back_to_back();
        clearExp();
        wordList[0] = 4'hF;
        wordList[1] = 4'h0;
        wordList[2] = 4'h0;
        for (int c = 0; c <= 24; c++) schedValid[c] = 1'b1;
        markWord(0, 4'hF);
        markWord(24, 4'h0);
        markLatch(49);
        runCapture(65);
        for (int c = 0; c < 65; c++) begin
            logic [4:0] e;
            e = {expLoad[c], expNext[c], expBusy[c], expFrame[c], expLed[c] ^ IDLE_LVL};
            nCompared++;
            if (obsVec[c] !== e) begin
                nMismatch++;
                $display("[TB] FAIL back_to_back c%0d {load,next,busy,done,dout}: got %b want %b", c, obsVec[c], e);
            end
        end
    endtask

    task automatic test_latch_ignores_valid();
        clearExp();
        wordList[0] = 4'b0110;
        wordList[1] = 4'b1001;
        wordList[2] = 4'b0000;
        schedValid[0]  = 1'b1;
        schedValid[27] = 1'b1;
        schedValid[28] = 1'b1;
        for (int c = 31; c <= 35; c++) schedValid[c] = 1'b1;
        markWord(0, 4'b0110);
        markLatch(25);
        markWord(35, 4'b1001);
        markLatch(60);
        runCapture(75);
        for (int c = 0; c < 75; c++) begin
            logic [4:0] e;
            e = {expLoad[c], expNext[c], expBusy[c], expFrame[c], expLed[c] ^ IDLE_LVL};
            nCompared++;
            if (obsVec[c] !== e) begin
                nMismatch++;
                $display("[TB] FAIL latch_valid c%0d {load,next,busy,done,dout}: got %b want %b", c, obsVec[c], e);
            end
        end
    endtask

    task automatic test_reset_mid_high();
        pendingWord = 4'b1000;
        word_valid  = 1'b1;
        @(negedge clk);
        nCompared++;
        if (load !== 1'b1) begin
            nMismatch++;
            $display("[TB] FAIL midhigh_first_load: got %b want 1", load);
        end
        @(posedge clk);
        #1;
        word_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        nCompared++;
        if ({busy, led_dout} !== {1'b1, ~IDLE_LVL}) begin
            nMismatch++;
            $display("[TB] FAIL midhigh_before_reset {busy,dout}: got %b want %b", {busy, led_dout}, {1'b1, ~IDLE_LVL});
        end
        reset = 1'b0;
        #1;
        nCompared++;
        if ({load, next_bit, busy, frame_done, led_dout} !== {4'b0000, IDLE_LVL}) begin
            nMismatch++;
            $display("[TB] FAIL midhigh_async_reset: got %b want %b", {load, next_bit, busy, frame_done, led_dout}, {4'b0000, IDLE_LVL});
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            nCompared++;
            if ({load, busy, led_dout} !== {2'b00, IDLE_LVL}) begin
                nMismatch++;
                $display("[TB] FAIL midhigh_release c%0d: got %b want %b", c, {load, busy, led_dout}, {2'b00, IDLE_LVL});
            end
        end
        @(posedge clk);
        #1;
        word_valid = 1'b1;
        @(negedge clk);
        nCompared++;
        if (load !== 1'b1) begin
            nMismatch++;
            $display("[TB] FAIL midhigh_reload: got %b want 1", load);
        end
        @(posedge clk);
        #1;
        word_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        nCompared++;
        if (busy !== 1'b0) begin
            nMismatch++;
            $display("[TB] FAIL midhigh_frame_end busy: got %b want 0", busy);
        end
    endtask

    initial begin
        reset       = 1'b0;
        word_valid  = 1'b0;
        pendingWord = 4'd0;
        wordPtr     = 0;
        for (int i = 0; i < 4; i++) wordList[i] = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_latch_ignores_valid();
        test_reset_mid_high();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
